// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive engine with glitch rejection and ready/ack handshake
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] data_out,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // Last count of a full bit period and of the half period to the start-bit centre
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_n;
    logic [7:0]      shift;
    logic [7:0]      shift_n;
    logic            load;
    logic            ovr_set;
    logic            ferr_set;

    // Two-flop synchroniser; idle-high reset so a reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state, bit timing counter, bit index and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // Next-state logic: centre-sample start, eight data bits and the stop bit
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        load      = 1'b0;
        ovr_set   = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_idx_n = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                        if (!rx_ready || rx_ack) begin
                            load = 1'b1;
                        end else begin
                            ovr_set = 1'b1;
                        end
                    end else begin
                        state_n  = WAIT_IDLE;
                        ferr_set = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output byte, level-valid handshake and one-cycle error pulses; a load beats an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= 8'h00;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                data_out <= shift;
                rx_ready <= 1'b1;
            end else if (rx_ack) begin
                rx_ready <= 1'b0;
            end
            frame_err <= ferr_set;
            overrun   <= ovr_set;
        end
    end

    assign busy = (state != IDLE);

endmodule
